// File: rtl/rr_arbiter8_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_pkg
// Shared definitions for the 8-way round-robin arbiter:
//   - N_REQ / ADDR_W sizing constants
//   - state_e : two-state arbiter FSM encoding (IDLE=0, GRANT=1)
//   - pick_t  : result of the round-robin priority search
//   - rr_pick : combinational search for the first set request bit,
//               starting at the pointer and wrapping around
// ---------------------------------------------------------------------------
package rr_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic              found;
        logic [ADDR_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... with 3-bit wrap; the first set bit wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0]  req_vec,
                                      input logic [ADDR_W-1:0] ptr);
        pick_t             p;
        logic [ADDR_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + ADDR_W'(i);
            if (!p.found && req_vec[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3to8.sv
// ---------------------------------------------------------------------------
// decoder3to8
// Plain 3-to-8 binary-to-one-hot decoder.
// Ports:
//   addr  in  3  binary index
//   y     out 8  one-hot decode of addr
// ---------------------------------------------------------------------------
module decoder3to8
    import rr_arbiter8_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]  y
);

    // Binary to one-hot decode
    always_comb begin
        y = 8'h00;
        case (addr)
            3'd0:    y = 8'h01;
            3'd1:    y = 8'h02;
            3'd2:    y = 8'h04;
            3'd3:    y = 8'h08;
            3'd4:    y = 8'h10;
            3'd5:    y = 8'h20;
            3'd6:    y = 8'h40;
            3'd7:    y = 8'h80;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// 8-requester round-robin arbiter with a hold limit. A grant is issued one
// cycle after a request is seen in IDLE, is kept while the owner keeps
// requesting, and is force-released after MAX_HOLD cycles (timeout pulse).
// Every release passes through one IDLE cycle before the next grant.
// Ports:
//   clk         in   1  clock, rising edge
//   reset       in   1  synchronous active-high reset
//   req         in   8  request vector (level)
//   grant_addr  out  3  index of current / last owner
//   grant       out  8  one-hot grant, 8'h00 when no owner
//   grant_valid out  1  an owner holds the resource
//   timeout     out  1  one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    output logic [ADDR_W-1:0] grant_addr,
    output logic [N_REQ-1:0]  grant,
    output logic              grant_valid,
    output logic              timeout
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] rr_ptr_q,     rr_ptr_d;
    logic [7:0]        hold_cnt_q,   hold_cnt_d;
    logic [ADDR_W-1:0] grant_addr_q, grant_addr_d;
    logic              timeout_q,    timeout_d;
    pick_t             pick_s;
    logic [N_REQ-1:0]  dec_s;

    // Next-state logic: arbitration in IDLE, hold/release decision in GRANT
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        grant_addr_d = grant_addr_q;
        timeout_d    = 1'b0;
        pick_s       = rr_pick(req, rr_ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_s.found) begin
                    state_d      = ST_GRANT;
                    grant_addr_d = pick_s.idx;
                    // Winner moves to lowest priority for the next round
                    rr_ptr_d     = pick_s.idx + 3'd1;
                    hold_cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[grant_addr_q]) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q >= MAX_HOLD_C) begin
                    // >= keeps the counter from ever running past the limit
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 3'd0;
            hold_cnt_q   <= 8'd0;
            grant_addr_q <= 3'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            grant_addr_q <= grant_addr_d;
            timeout_q    <= timeout_d;
        end
    end

    decoder3to8 u_dec (
        .addr (grant_addr_q),
        .y    (dec_s)
    );

    assign grant_valid = (state_q == ST_GRANT);
    assign grant_addr  = grant_addr_q;
    assign grant       = dec_s & {N_REQ{grant_valid}};
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed bench for rr_arbiter8 (MAX_HOLD=4). Each step drives reset/req,
// queues the outputs expected after the next rising edge, then pops and
// checks them 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

    typedef struct {
        logic       gv;
        logic [2:0] ga;
        logic [7:0] gr;
        logic       to;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [2:0] grant_addr;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout;

    int   total;
    int   bad;
    exp_t sb_q[$];

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant_addr  (grant_addr),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle and check outputs after the edge against the queue head
    task automatic step(input string tag, input logic rst, input logic [7:0] r,
                        input logic ev, input logic [2:0] ea, input logic et);
        exp_t e;
        exp_t got;
        logic [7:0] one;
        one   = 8'h01;
        e.gv  = ev;
        e.ga  = ea;
        e.gr  = ev ? (one << ea) : 8'h00;
        e.to  = et;
        reset = rst;
        req   = r;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        total++;
        assert (grant_valid === got.gv) else begin
            bad++;
            $error("FAIL %s grant_valid got=%b exp=%b", tag, grant_valid, got.gv);
        end
        total++;
        assert (grant_addr === got.ga) else begin
            bad++;
            $error("FAIL %s grant_addr got=%0d exp=%0d", tag, grant_addr, got.ga);
        end
        total++;
        assert (grant === got.gr) else begin
            bad++;
            $error("FAIL %s grant got=%h exp=%h", tag, grant, got.gr);
        end
        total++;
        assert (timeout === got.to) else begin
            bad++;
            $error("FAIL %s timeout got=%b exp=%b", tag, timeout, got.to);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = 8'h00;

        // Reset, then idle with no requests
        step("reset", 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // 8'h24: addr 2 first, release, one gap, then addr 5
        step("r24_g2",   1'b0, 8'h24, 1'b1, 3'd2, 1'b0);
        step("r24_hold", 1'b0, 8'h24, 1'b1, 3'd2, 1'b0);
        step("r20_rel",  1'b0, 8'h20, 1'b0, 3'd2, 1'b0);
        step("r20_g5",   1'b0, 8'h20, 1'b1, 3'd5, 1'b0);
        step("r00_rel",  1'b0, 8'h00, 1'b0, 3'd5, 1'b0);

        // All requesting: 0..7,0 each 4 cycles, timeout pulse in each gap
        step("reset2", 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++)
                step("ff_own", 1'b0, 8'hFF, 1'b1, 3'(k % 8), 1'b0);
            step("ff_tmo", 1'b0, 8'hFF, 1'b0, 3'(k % 8), 1'b1);
        end

        // Reset beats requests; mid-grant reset drops grant on that edge
        step("rst_pri",  1'b1, 8'hFF, 1'b0, 3'd0, 1'b0);
        step("g3",       1'b0, 8'h08, 1'b1, 3'd3, 1'b0);
        step("g3_hold",  1'b0, 8'h08, 1'b1, 3'd3, 1'b0);
        step("rst_mid",  1'b1, 8'h08, 1'b0, 3'd0, 1'b0);
        step("g3_again", 1'b0, 8'h08, 1'b1, 3'd3, 1'b0);
        step("g3_rel",   1'b0, 8'h00, 1'b0, 3'd3, 1'b0);

        // Wrap: grant 6 leaves pointer at 7, then 8'h81 serves 7 then 0
        step("g6",       1'b0, 8'h40, 1'b1, 3'd6, 1'b0);
        step("g6_rel",   1'b0, 8'h00, 1'b0, 3'd6, 1'b0);
        step("w_g7",     1'b0, 8'h81, 1'b1, 3'd7, 1'b0);
        step("w_g7h",    1'b0, 8'h81, 1'b1, 3'd7, 1'b0);
        step("w_rel7",   1'b0, 8'h01, 1'b0, 3'd7, 1'b0);
        step("w_g0",     1'b0, 8'h01, 1'b1, 3'd0, 1'b0);
        step("w_rel0",   1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // Single-cycle request pulse: one grant cycle, no timeout
        step("p_g0",     1'b0, 8'h01, 1'b1, 3'd0, 1'b0);
        step("p_rel",    1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        step("p_idle",   1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        // Timed-out owner 4 goes behind pending requester 0
        for (int c = 0; c < 4; c++) step("t_g4", 1'b0, 8'h11, 1'b1, 3'd4, 1'b0);
        step("t_tmo4",   1'b0, 8'h11, 1'b0, 3'd4, 1'b1);
        step("t_g0",     1'b0, 8'h11, 1'b1, 3'd0, 1'b0);
        step("t_rel0",   1'b0, 8'h00, 1'b0, 3'd0, 1'b0);

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
